wb_machine_timer: RTL
=====================

# wb_machine_timer

Wishbone classic slave providing a RISC-V style 64-bit machine timer (mtime/mtimecmp) with a level timer interrupt. It is attached to one slave port of the SoC Wishbone interconnect, alongside GPIO, data memory and instruction memory. Its interrupt output feeds the core's machine timer interrupt input. Software uses it for delays, timeouts and scheduler ticks.

## Interface
Parameters:
- RESET_CMP, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp, so no interrupt fires out of reset.

Ports:
- clk  in  1  system clock; sole clock domain.
- reset_n  in  1  synchronous, active-low reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_adr_i  in  5  byte address within the block; bits [4:2] select the register, bits [1:0] are ignored.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lane enables for writes.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid only while wb_ack_o is high.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination for an unmapped offset.
- timer_irq_o  out  1  level machine timer interrupt.

## Operation
Register map (byte offsets):
- 0x00 MTIME_LO: R/W.
- 0x04 MTIME_HI: R/W. A read returns the shadow latched by the last MTIME_LO read.
- 0x08 MTIMECMP_LO: R/W.
- 0x0C MTIMECMP_HI: R/W.
- 0x10 CTRL: R/W.
  - bit0 EN enables counting.
  - bit1 IE enables the interrupt.
  - bits [31:2] read as 0.
- 0x14 PRESCALE: R/W, bits [15:0]. Present only with the macro; see Configuration.
- 0x18 STATUS: read-only. bit0 = (mtime >= mtimecmp), independent of IE. Writes are acked and ignored.
- 0x1C: unmapped. Any access terminates with wb_err_o and has no side effect.

Counter:
- mtime increments by 1 on each tick while EN=1.
- The counter is a 64-bit unsigned value and wraps from 2^64-1 to 0 with no flag.
- A bus write to MTIME_LO or MTIME_HI takes precedence over the tick in the same cycle. The written half takes the new data byte-masked by wb_sel_i. The other half holds; it is not incremented.

Other register rules:
- Writes to every R/W register honour wb_sel_i per byte.
- Comparison is unsigned 64-bit: timer_irq_o = IE & (mtime >= mtimecmp).
- EN does not gate the comparison. A stopped timer can still assert the interrupt.
- Reading MTIME_LO captures mtime[63:32] into a 32-bit shadow in the same cycle. This gives a coherent 64-bit read as LO followed by HI.

## Timing
Reset:
- Reset values: mtime=0, mtimecmp=RESET_CMP, CTRL=0, PRESCALE=0, shadow=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, timer_irq_o=0.
- Reset asserted in the middle of an access drops ack/err on the next edge. Any pending access is discarded.

Bus handshake:
- An access is sampled at edge N when wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o.
- The register write, or the read data capture, happens at edge N.
- wb_ack_o (or wb_err_o) is high for exactly one cycle, N to N+1. wb_dat_o is valid in that same cycle.
- Maximum throughput is one access per 2 cycles. Back-to-back strobes receive alternating acks.
- wb_dat_o returns 0 when no ack is pending.
- A read of MTIME returns the value present at edge N, i.e. before any tick at that edge.
- A strobe deasserted before the ack is not supported. The ack is still issued one cycle later.

Interrupt:
- timer_irq_o is registered. It rises or falls one cycle after the condition changes.
- Example: mtimecmp written to a value ≤ mtime at edge N gives irq high at edge N+1.
- Example: mtimecmp written above mtime at edge N gives irq low at edge N+1.

## Configuration
Macro: TIMER_PRESCALE_EN.

Defined:
- A 16-bit prescale counter runs while EN=1.
- A tick occurs when the prescale counter equals PRESCALE; the counter then reloads 0.
- PRESCALE=0 gives a tick every cycle.
- A write to PRESCALE clears the prescale counter.
- Clearing EN holds the prescale counter.

Undefined:
- A tick occurs every cycle while EN=1.
- Offset 0x14 is acked, reads 0, and writes are ignored. It does not return an error.

## Structure
- Package timer_pkg holds:
  - localparams for the register offsets (TMR_MTIME_LO … TMR_STATUS);
  - CTRL bit indices (CTRL_EN=0, CTRL_IE=1);
  - the PRESCALE width (16).
- One sub-module, timer_prescaler: prescale counter plus tick generation.
  - Under TIMER_PRESCALE_EN it holds the counter.
  - Otherwise it reduces to tick = en.
- Everything else lives in wb_machine_timer.

## Test plan
- Reset, then read all offsets → MTIME=0, MTIMECMP=FFFFFFFF/FFFFFFFF, CTRL=0, STATUS=0, timer_irq_o=0. Each read acks 1 cycle after the strobe.
- Write CTRL=1, wait 10 cycles, read MTIME_LO → value in 10..12. MTIME_HI=0.
- Write MTIME_LO=FFFFFFFE and MTIME_HI=0 with EN=1, then read LO then HI → LO wraps through 0, and HI equals 1 (the shadow) once LO < FFFFFFFE.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=3 → timer_irq_o rises one cycle after mtime reaches 20. Writing MTIMECMP_LO=FFFFFFFF drops it one cycle after that write.
- Access offset 0x1C → wb_err_o pulses 1 cycle, wb_ack_o stays 0, and no register changes. A byte write with sel=4'b0010, data=0000AB00 to MTIMECMP_LO changes only byte 1.
- With TIMER_PRESCALE_EN: PRESCALE=3, EN=1 → mtime increments once every 4 cycles. Without the macro: PRESCALE reads 0 after writing 3.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, CTRL bit indices, prescale width and byte-lane merge for wb_machine_timer.
package timer_pkg;
    localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
    localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
    localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] TMR_CTRL        = 5'h10;
    localparam logic [4:0] TMR_PRESCALE    = 5'h14;
    localparam logic [4:0] TMR_STATUS      = 5'h18;
    localparam logic [4:0] TMR_UNMAPPED    = 5'h1C;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_IE    = 1;
    localparam int PRESCALE_W = 16;

    function automatic logic [31:0] byte_merge(input logic [31:0] cur, input logic [31:0] wdat,
                                               input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : cur[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: mtime tick generator; with TIMER_PRESCALE_EN a 16-bit divider, otherwise tick = en.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  clr_i,
    output logic                  tick_o
);
`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] cnt_q;
    assign tick_o = en_i && cnt_q == prescale_i;
    always_ff @(posedge clk) begin
        if (!reset_n || clr_i) cnt_q <= '0;
        else if (en_i)         cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, reset_n, clr_i, prescale_i};
    assign tick_o = en_i;
`endif
endmodule

// File: rtl/wb_machine_timer.sv
// wb_machine_timer: Wishbone classic RISC-V mtime/mtimecmp timer with level irq; TIMER_PRESCALE_EN enables PRESCALE.
module wb_machine_timer
    import timer_pkg::*;
#(
    parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [4:0]  wb_adr_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        timer_irq_o
);
    logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
    logic [31:0] shadow_q, shadow_d, dat_q, dat_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic ack_q, ack_d, err_q, err_d, irq_q, irq_d, acc, wr, tick;
    logic [4:0] off;

    assign off = wb_adr_i & 5'h1C;
    assign acc = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign wr  = acc & wb_we_i;

    timer_prescaler u_presc (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (ctrl_q[CTRL_EN]),
        .prescale_i(presc_q),
        .clr_i     (wr && off == TMR_PRESCALE),
        .tick_o    (tick)
    );

    always_comb begin
        mtime_d  = mtime_q + {63'd0, tick};
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        shadow_d = shadow_q;
        dat_d    = '0;
        ack_d    = acc && off != TMR_UNMAPPED;
        err_d    = acc && off == TMR_UNMAPPED;
        irq_d    = ctrl_q[CTRL_IE] && mtime_q >= cmp_q;
        if (wr) begin
            // an mtime write replaces the tick; the unwritten half holds
            case (off)
                TMR_MTIME_LO:    mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], wb_dat_i, wb_sel_i)};
                TMR_MTIME_HI:    mtime_d = {byte_merge(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
                TMR_MTIMECMP_LO: cmp_d[31:0]  = byte_merge(cmp_q[31:0], wb_dat_i, wb_sel_i);
                TMR_MTIMECMP_HI: cmp_d[63:32] = byte_merge(cmp_q[63:32], wb_dat_i, wb_sel_i);
                TMR_CTRL:        ctrl_d = wb_sel_i[0] ? wb_dat_i[1:0] : ctrl_q;
`ifdef TIMER_PRESCALE_EN
                TMR_PRESCALE:    presc_d = {wb_sel_i[1] ? wb_dat_i[15:8] : presc_q[15:8],
                                            wb_sel_i[0] ? wb_dat_i[7:0]  : presc_q[7:0]};
`endif
                default: ;
            endcase
        end else if (acc) begin
            case (off)
                TMR_MTIME_LO: begin
                    dat_d    = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                TMR_MTIME_HI:    dat_d = shadow_q;
                TMR_MTIMECMP_LO: dat_d = cmp_q[31:0];
                TMR_MTIMECMP_HI: dat_d = cmp_q[63:32];
                TMR_CTRL:        dat_d = {30'd0, ctrl_q};
                TMR_PRESCALE:    dat_d = 32'(presc_q);
                TMR_STATUS:      dat_d = {31'd0, mtime_q >= cmp_q};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mtime_q  <= '0;
            cmp_q    <= RESET_CMP;
            ctrl_q   <= '0;
            presc_q  <= '0;
            shadow_q <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            shadow_q <= shadow_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign timer_irq_o = irq_q;
endmodule
